// File: rtl/uart_tx.sv
// uart_tx - byte-oriented 8N1 UART transmitter with a transmit FIFO.
//
// Bytes written with we/Data_in are queued in a circular FIFO. Each byte
// leaves on tx as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
// Every bit lasts CLKS_PER_BIT clock cycles. Frames run back to back while
// the FIFO holds data.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   we       in   write enable; Data_in is queued when full=0
//   Data_in  in   byte to transmit
//   full     out  FIFO holds FIFO_DEPTH entries
//   empty    out  FIFO holds no entries
//   busy     out  a frame is in progress or the FIFO holds data
//   overflow out  sticky: a write was attempted while full (cleared by rst)
//   tx       out  serial line, registered, idles high
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] Data_in,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = FIFO_AW + 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_overflow;

  logic               w_baud_done;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count_nxt;
  logic [7:0]         w_head;

  // Handshake decode: push/pop strobes and the next FIFO occupancy.
  always_comb begin
    w_baud_done = (r_baud == BAUD_LAST);
    w_push      = we & ~r_full;
    w_head      = r_mem[r_rd_ptr];
    // Pop either from idle or on the final stop-bit cycle, so consecutive
    // frames follow without an idle gap.
    if (!r_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done))) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents are not reset, reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Data_in;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == COUNT_FULL);
      r_empty <= (w_count_nxt == CW'(0));
      // A write against a full FIFO is lost even if a pop frees a slot now.
      if (we && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop; tx and busy registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_tx    <= 1'b1;
            r_busy  <= w_push;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud  <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              // Next bit comes from shift[1], which becomes shift[0] after the shift.
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_bit   <= 3'd0;
              r_state <= S_START;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= w_push;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= ~r_empty;
        end
      endcase
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - self-checking bench for uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=16).
//
// Reference model: a byte queue for the FIFO plus a "cycles left in the
// current frame" counter; the expected tx level is the frame bit selected by
// position-in-frame / CLKS_PER_BIT. A separate line decoder turns tx back
// into bytes that are compared with the accepted write order.
module tb_uart_tx;

  localparam int C     = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * C;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] Data_in;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;
  logic       tx;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .Data_in  (Data_in),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur = 8'h00;
  int         m_fl  = 0;
  logic       m_ovf = 1'b0;

  // decoder state
  logic [7:0] dec_q[$];
  logic       dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int bi;
    if (m_fl == 0) return 1'b1;
    bi = (FRAME - m_fl) / C;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return m_cur[bi-1];
  endfunction

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic w, input logic [7:0] d);
    logic push;
    logic pop;
    int   k;
    rst = r; we = w; Data_in = d;
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_sent.delete(); dec_q.delete();
      m_fl = 0; m_ovf = 1'b0;
    end else begin
      if (m_fl > 0) m_fl--;
      push = w && (m_q.size() < DEPTH);
      if (w && (m_q.size() == DEPTH)) m_ovf = 1'b1;
      pop = (m_fl == 0) && (m_q.size() > 0);
      if (pop) begin
        m_cur = m_q.pop_front();
        m_fl  = FRAME;
      end
      if (push) begin
        m_q.push_back(d);
        m_sent.push_back(d);
      end
    end
    #1;
    check("tx",       {31'd0, tx},       {31'd0, exp_tx()});
    check("full",     {31'd0, full},     {31'd0, (m_q.size() == DEPTH)});
    check("empty",    {31'd0, empty},    {31'd0, (m_q.size() == 0)});
    check("busy",     {31'd0, busy},     {31'd0, ((m_fl > 0) || (m_q.size() > 0))});
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    // line decoder: sample each bit in the middle of its period
    if (r) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (tx === 1'b0) begin
        dec_act = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt >= C/2 + C) && (((dec_cnt - C/2) % C) == 0)) begin
        k = (dec_cnt - C/2) / C;
        if (k <= 8) begin
          dec_byte[k-1] = tx;
        end else begin
          dec_q.push_back(dec_byte);
          dec_act = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3000; k++) begin
      if ((m_fl == 0) && (m_q.size() == 0)) break;
      step(1'b0, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_decoded(input string tag);
    check({tag, "_count"}, dec_q.size(), m_sent.size());
    for (int i = 0; i < m_sent.size() && i < dec_q.size(); i++) begin
      check({tag, "_byte"}, {24'd0, dec_q[i]}, {24'd0, m_sent[i]});
    end
    dec_q.delete();
    m_sent.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    int guard;
    rst = 1'b1; we = 1'b0; Data_in = 8'h00;

    // reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_tx",    {31'd0, tx},    32'd1);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);

    // single byte 0xA5: start edge two edges after the write
    step(1'b0, 1'b1, 8'hA5);
    check("a5_tx_after_write", {31'd0, tx}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    check("a5_start_edge", {31'd0, tx}, 32'd0);
    for (int k = 0; k < 39; k++) step(1'b0, 1'b0, 8'h00);
    check("a5_busy_39", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b0, 8'h00);
    check("a5_busy_40", {31'd0, busy}, 32'd0);
    drain();
    compare_decoded("a5");

    // three back-to-back frames
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'h80);
    step(1'b0, 1'b1, 8'hFF);
    drain();
    compare_decoded("b2b");

    // fill: 17 writes, the pop at edge 2 makes room for 0x10
    for (int k = 0; k < 17; k++) step(1'b0, 1'b1, 8'(k));
    check("fill_full", {31'd0, full},     32'd1);
    check("fill_ovf",  {31'd0, overflow}, 32'd0);

    // write while full on the exact pop cycle
    guard = 0;
    while ((m_fl != 1) && (guard < 200)) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    check("pop_wait_timeout", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    step(1'b0, 1'b1, 8'h55);
    check("ovf_set",     {31'd0, overflow}, 32'd1);
    check("ovf_notfull", {31'd0, full},     32'd0);
    drain();
    compare_decoded("fill");

    // reset in the middle of data bit 3
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    guard = 0;
    while (!((m_fl > 0) && (((FRAME - m_fl) / C) == 4)) && (guard < 200)) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    check("bit3_wait_timeout", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    step(1'b1, 1'b0, 8'h00);
    check("midrst_tx",    {31'd0, tx},    32'd1);
    check("midrst_empty", {31'd0, empty}, 32'd1);
    check("midrst_busy",  {31'd0, busy},  32'd0);
    for (int k = 0; k < 60; k++) step(1'b0, 1'b0, 8'h00);
    check("midrst_no_frames", dec_q.size(), 32'd0);

    // pointer wrap: 40 incrementing bytes with random gaps, never overfilling
    i = 0;
    guard = 0;
    while ((i < 40) && (guard < 5000)) begin
      if ((m_q.size() < DEPTH) && ($urandom_range(0, 3) != 0)) begin
        step(1'b0, 1'b1, 8'(i));
        i++;
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      guard++;
    end
    drain();
    check("wrap_ovf", {31'd0, overflow}, 32'd0);
    compare_decoded("wrap");

    // random traffic, overflow allowed
    for (int k = 0; k < 800; k++) begin
      step(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
    end
    drain();
    compare_decoded("rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
